// File: rtl/rv32_mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// The RV32_MDU_FAST_MUL_EN build option is consumed by rv32_mdu_iter.
package rv32_mdu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Two's-complement magnitude when the value is to be treated as negative.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step
  import rv32_mdu_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem_i < divisor_i, so rem_sh < 2*divisor and bit XLEN of diff is a clean borrow flag.
  always_comb begin
    rem_sh = {rem_i, quot_i[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32_mdu_iter.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Define RV32_MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module rv32_mdu_iter
  import rv32_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quot_q, quot_d;
  logic                a_neg_q, a_neg_d;
  logic                b_neg_q, b_neg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN-1:0]     step_rem, step_quot;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix, fix_res;

  // Operand signedness decoded from funct3 of the incoming request.
  always_comb begin
    a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    b_sgn = op[2] ? ~op[0] : ~op[1];
    a_neg = a_sgn & opA[XLEN-1];
    b_neg = b_sgn & opB[XLEN-1];
    a_mag = mag(opA, a_neg);
    b_mag = mag(opB, b_neg);
  end

`ifdef RV32_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  // Low 64 bits of the product of extended operands are exact for every signedness mix.
  assign fast_a    = {{XLEN{a_neg}}, opA};
  assign fast_b    = {{XLEN{b_neg}}, opB};
  assign fast_prod = fast_a * fast_b;
`endif

  assign mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};

  mdu_div_step u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // Sign fix-up of the magnitude results, evaluated while in StDone.
  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quot_fix = mag(quot_q, a_neg_q ^ b_neg_q);
    rem_fix  = mag(rem_q, a_neg_q);
    if (!op_q[2]) begin
      fix_res = (op_q == OpMul) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else if (divisor_q == '0) begin
      // rem_q holds the raw dividend on the divide-by-zero path.
      fix_res = (op_q inside {OpRem, OpRemu}) ? rem_q : DIV0_QUOT;
    end else begin
      fix_res = (op_q inside {OpRem, OpRemu}) ? rem_fix : quot_fix;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = mdu_op_e'(op);
          cnt_d   = '0;
          a_neg_d = a_neg;
          b_neg_d = b_neg;
          if (op[2]) begin
            divisor_d = b_mag;
            quot_d    = a_mag;
            if (opB == '0) begin
              rem_d   = opA;
              state_d = StDone;
            end else begin
              rem_d   = '0;
              state_d = StDiv;
            end
          end else begin
`ifdef RV32_MDU_FAST_MUL_EN
            prod_d  = fast_prod;
            a_neg_d = 1'b0;
            b_neg_d = 1'b0;
            state_d = StDone;
`else
            mcand_d = a_mag;
            prod_d  = {{XLEN{1'b0}}, b_mag};
            state_d = StMul;
`endif
          end
        end
      end
      StMul: begin
        prod_d = {mul_sum, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDiv: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone: begin
        result_d = fix_res;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    done   = (state_q == StDone);
    result = done ? fix_res : result_q;
  end

endmodule

// File: tb/tb_rv32_mdu_iter.sv
// Directed self-checking bench for rv32_mdu_iter (honours RV32_MDU_FAST_MUL_EN).
module tb_rv32_mdu_iter;

`ifdef RV32_MDU_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  rv32_mdu_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Start is sampled in cycle 0; returns at the falling edge of cycle 1.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle number in which done is seen, or -1 on timeout.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < c0 + 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b want 1", i, busy); end
      wait_done(1, cyc);
      checks++; if (cyc !== MulLat) begin errors++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, cyc, MulLat); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL mul_res[%0d]: got %h want %h", i, result, exp[i]); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul_after[%0d]: busy %b done %b want 0 0", i, busy, done); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL mul_hold[%0d]: got %h want %h", i, result, exp[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'h80000000, 32'h0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(1, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL div_lat[%0d]: got %0d want 33", i, cyc); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL div_res[%0d]: got %h want %h", i, result, exp[i]); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_after[%0d]: busy %b want 0", i, busy); end
    end
  endtask

  task automatic test_div_zero();
    logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], 32'd0);
      checks++; if (busy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL dz_cycle1[%0d]: busy %b done %b want 1 1", i, busy, done); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL dz_res[%0d]: got %h want %h", i, result, exp[i]); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_after[%0d]: busy %b want 0", i, busy); end
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    issue(3'b100, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ign_c10: busy %b done %b want 1 0", busy, done); end
    op = 3'b111; opA = 32'd50; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL ign_lat: got %0d want 33", cyc); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL ign_res: got %h want %h", result, 32'd14); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_c34: busy %b want 0", busy); end
    op = 3'b101; opA = 32'hFFFFFFFF; opB = 32'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_accept: busy %b want 1", busy); end
    wait_done(35, cyc);
    checks++; if (cyc !== 67) begin errors++; $display("FAIL ign_lat2: got %0d want 67", cyc); end
    checks++; if (result !== 32'h0FFFFFFF) begin errors++; $display("FAIL ign_res2: got %h want %h", result, 32'h0FFFFFFF); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int seen;
    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl: busy %b done %b want 0 0", busy, done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_mid_res: got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", seen); end
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, cyc);
    checks++; if (cyc !== MulLat) begin errors++; $display("FAIL rst_next_lat: got %0d want %0d", cyc, MulLat); end
    checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL rst_next_res: got %h want %h", result, 32'hFFFFFFFE); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_mdu_iter.md
Name: rv32_mdu_iter

Overview:
Iterative RV32M multiply/divide unit directly downstream of the ALU operand-B select stage. Consumes operand A (RU[rs1]) and operand B (selected RU[rs2]/immgen value) plus funct3. Produces the 32-bit M-extension result with a start/busy/done handshake. Core control holds the instruction while busy is high.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opA  in  XLEN  operand A (rs1)
opB  in  XLEN  operand B (from operand-B select stage)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; result valid this cycle and held afterwards
result  out  XLEN  result; held until the next accepted start

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- States:
  - IDLE: start=1 latches op, opA, opB, takes operand magnitudes and sign flags, clears count.
  - MUL: shift-add, 1 bit/cycle, 64-bit product register.
  - DIV: restoring divide, 1 bit/cycle, 32-bit quotient and remainder registers.
  - DONE: sign fix-up, result written, done=1, then return to IDLE.
- Transitions:
  - IDLE->MUL for op[2]=0.
  - IDLE->DIV for op[2]=1 with opB!=0.
  - IDLE->DONE for op[2]=1 with opB==0 (fast path).
  - MUL/DIV->DONE after 32 iterations (count 0..31).
  - DONE->IDLE always.
- Latency, start in cycle 0:
  - Iterative ops: busy=1 in cycles 1..33; done=1 and result valid in cycle 33.
  - Divide by zero: busy=1 and done=1 in cycle 1.
- busy deasserts in the cycle after done, so a new start is accepted in cycle 34 (or cycle 2 for divide by zero).
- start while busy=1 is ignored. Operand/op changes while busy=1 have no effect.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Datapath works on magnitudes; fix-up applies the sign:
  - Product negated if signs differ.
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- MUL returns product[31:0]. MULH, MULHSU and MULHU return product[63:32].
- Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=opA.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV result=0x80000000; REM result=0. Produced by the normal path; no trap.
- rst_n low mid-operation: immediate return to IDLE with all outputs at reset values; no done for the aborted op.
- done and start in the same cycle: impossible to accept, since busy=1 during DONE.

Optional Feature:
RV32_MDU_FAST_MUL_EN
- Defined: MUL* ops use a single combinational 64-bit signed/unsigned product. IDLE->DONE directly, so busy and done are both 1 in cycle 1 after start. Divide is unchanged.
- Undefined: MUL* ops use the iterative 33-cycle path described above.

Decomposition:
- Package rv32_mdu_pkg holds:
  - XLEN localparam.
  - mdu_op_e enum (8 funct3 encodings).
  - mdu_state_e enum (IDLE, MUL, DIV, DONE).
  - DIV0_QUOT constant 32'hFFFFFFFF.
- One sub-module, mdu_div_step: combinational single restoring-division step. Inputs: remainder, quotient, divisor magnitude. Outputs: next remainder and next quotient. Instantiated once in rv32_mdu_iter.

Test Plan:
- MUL opA=7, opB=0xFFFFFFFD, start -> done in cycle 33, result=0xFFFFFFEB. With RV32_MDU_FAST_MUL_EN: done in cycle 1.
- MULHU opA=opB=0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU opA=0xFFFFFFFF, opB=2 -> 0xFFFFFFFF.
- DIV opA=0xFFFFFFF9 (-7), opB=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done in cycle 1, result=0xFFFFFFFF. REMU 5/0 -> result=5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Second start with different operands in cycle 10 of a DIV -> ignored; first result returned in cycle 33; new start accepted in cycle 34.
- rst_n pulsed low in cycle 15 of a MUL -> busy=0, done=0, result=0 immediately; no done pulse follows; next start completes normally.
